// File: rtl/y86_regfile_decode.sv
// y86_regfile_decode: Y86 register file with registered decode read stage,
// dual write-back (E/M, M wins) with bypass, and a sequential register dump engine.
module y86_regfile_decode #(
  parameter int DATA_W = 64,
  parameter int ADDR_W = 4,
  parameter int NREG = 15,
  parameter int SP_IDX = 4,
  parameter logic [DATA_W-1:0] SP_INIT = '0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              dec_valid,
  input  logic [3:0]        icode,
  input  logic [ADDR_W-1:0] rA,
  input  logic [ADDR_W-1:0] rB,
  input  logic [ADDR_W-1:0] dstE,
  input  logic [DATA_W-1:0] valE,
  input  logic [ADDR_W-1:0] dstM,
  input  logic [DATA_W-1:0] valM,
  input  logic              dump_start,
  output logic [ADDR_W-1:0] srcA,
  output logic [ADDR_W-1:0] srcB,
  output logic [DATA_W-1:0] valA,
  output logic [DATA_W-1:0] valB,
  output logic              dec_out_valid,
  output logic              dump_busy,
  output logic              dump_valid,
  output logic [ADDR_W-1:0] dump_idx,
  output logic [DATA_W-1:0] dump_data
);
  localparam logic [ADDR_W-1:0] RNONE = '1;
  localparam logic [ADDR_W-1:0] SP = ADDR_W'(SP_IDX);
  localparam logic [ADDR_W-1:0] LAST = ADDR_W'(NREG - 1);
  typedef enum logic {IDLE, DUMP} state_t;
  state_t state, state_nx;
  logic [DATA_W-1:0] regs [NREG];
  logic [ADDR_W-1:0] sel_a, sel_b, idx;
  // Reads see this cycle's write-back; M checked first so bypass matches the write priority.
  function automatic logic [DATA_W-1:0] rd(input logic [ADDR_W-1:0] s);
    return int'(s) >= NREG ? '0 : dstM == s ? valM : dstE == s ? valE : regs[s];
  endfunction
  always_comb begin
    sel_a = icode inside {4'h2, 4'h4, 4'h6, 4'hA} ? rA : icode inside {4'h9, 4'hB} ? SP : RNONE;
    sel_b = icode inside {4'h4, 4'h5, 4'h6} ? rB : icode inside {4'h8, 4'h9, 4'hA, 4'hB} ? SP : RNONE;
    state_nx = state == IDLE ? (dump_start ? DUMP : IDLE) : (idx == LAST ? IDLE : DUMP);
  end
  assign dump_busy = state == DUMP;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n)
      for (int i = 0; i < NREG; i++) regs[i] <= i == SP_IDX ? SP_INIT : '0;
    else
      for (int i = 0; i < NREG; i++)
        if (dstM == ADDR_W'(i)) regs[i] <= valM;
        else if (dstE == ADDR_W'(i)) regs[i] <= valE;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      srcA <= RNONE;
      srcB <= RNONE;
      valA <= '0;
      valB <= '0;
      dec_out_valid <= 1'b0;
    end else begin
      dec_out_valid <= dec_valid;
      if (dec_valid) begin
        srcA <= sel_a;
        srcB <= sel_b;
        valA <= rd(sel_a);
        valB <= rd(sel_b);
      end
    end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state <= IDLE;
      idx <= '0;
      dump_valid <= 1'b0;
      dump_idx <= '0;
      dump_data <= '0;
    end else begin
      state <= state_nx;
      idx <= state == DUMP ? idx + 1'b1 : '0;
      dump_valid <= state == DUMP;
      if (state == DUMP) begin
        dump_idx <= idx;
        dump_data <= rd(idx);
      end
    end
endmodule

// File: tb/tb_y86_regfile_decode.sv
// tb_y86_regfile_decode: directed vector table, dump/reset sequences, and
// randomized traffic checked against an array-based register file model.
module tb_y86_regfile_decode;
  localparam logic [63:0] SPV = 64'h100;
  logic clk = 0, rst_n = 0, dec_valid = 0, dump_start = 0;
  logic [3:0] icode = 0, rA = 4'hF, rB = 4'hF, dstE = 4'hF, dstM = 4'hF;
  logic [63:0] valE = 0, valM = 0;
  logic [3:0] srcA, srcB, dump_idx;
  logic [63:0] valA, valB, dump_data;
  logic dec_out_valid, dump_busy, dump_valid;
  y86_regfile_decode #(.SP_INIT(SPV)) dut (
    .clk(clk), .rst_n(rst_n), .dec_valid(dec_valid), .icode(icode), .rA(rA), .rB(rB),
    .dstE(dstE), .valE(valE), .dstM(dstM), .valM(valM), .dump_start(dump_start),
    .srcA(srcA), .srcB(srcB), .valA(valA), .valB(valB), .dec_out_valid(dec_out_valid),
    .dump_busy(dump_busy), .dump_valid(dump_valid), .dump_idx(dump_idx), .dump_data(dump_data));
  always #5 clk = ~clk;
  typedef struct {
    logic dv;
    logic [3:0] ic, ra, rb, de;
    logic [63:0] ve;
    logic [3:0] dm;
    logic [63:0] vm;
    logic [3:0] xa, xb;
    logic [63:0] xva, xvb;
    logic xdov;
  } vec_t;
  vec_t tbl [9];
  logic [63:0] m [15];
  logic [3:0] e_srcA = 4'hF, e_srcB = 4'hF;
  logic [63:0] e_valA = 0, e_valB = 0;
  logic e_dov = 0;
  int vecs = 0, errs = 0;
  task automatic chk(input string n, input logic [63:0] act, input logic [63:0] exp);
    vecs++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %h expected %h", n, act, exp);
    end
  endtask
  function automatic logic [3:0] pick_a(input logic [3:0] ic, input logic [3:0] r);
    case (ic)
      4'h2, 4'h4, 4'h6, 4'hA: return r;
      4'h9, 4'hB: return 4'd4;
      default: return 4'hF;
    endcase
  endfunction
  function automatic logic [3:0] pick_b(input logic [3:0] ic, input logic [3:0] r);
    case (ic)
      4'h4, 4'h5, 4'h6: return r;
      4'h8, 4'h9, 4'hA, 4'hB: return 4'd4;
      default: return 4'hF;
    endcase
  endfunction
  task automatic model_reset();
    for (int i = 0; i < 15; i++) m[i] = i == 4 ? SPV : 64'd0;
    e_srcA = 4'hF; e_srcB = 4'hF; e_valA = 0; e_valB = 0; e_dov = 0;
  endtask
  // The model commits this cycle's writes first, then reads the committed state.
  task automatic step();
    if (dstE < 15) m[dstE] = valE;
    if (dstM < 15) m[dstM] = valM;
    e_dov = dec_valid;
    if (dec_valid) begin
      e_srcA = pick_a(icode, rA);
      e_srcB = pick_b(icode, rB);
      e_valA = e_srcA < 15 ? m[e_srcA] : 64'd0;
      e_valB = e_srcB < 15 ? m[e_srcB] : 64'd0;
    end
    @(posedge clk); #1;
  endtask
  task automatic idle_in();
    dec_valid = 0; icode = 0; dstE = 4'hF; dstM = 4'hF; dump_start = 0;
  endtask
  task automatic check_dec(input string tag);
    chk({tag, " srcA"}, 64'(srcA), 64'(e_srcA));
    chk({tag, " srcB"}, 64'(srcB), 64'(e_srcB));
    chk({tag, " valA"}, valA, e_valA);
    chk({tag, " valB"}, valB, e_valB);
    chk({tag, " dec_out_valid"}, 64'(dec_out_valid), 64'(e_dov));
  endtask
  task automatic dump_check(input string tag, input bit poke);
    idle_in();
    dump_start = 1;
    step();
    dump_start = 0;
    chk({tag, " busy at start"}, 64'(dump_busy), 64'd1);
    chk({tag, " valid at start"}, 64'(dump_valid), 64'd0);
    for (int k = 0; k < 15; k++) begin
      if (poke && k == 5) dump_start = 1;
      step();
      dump_start = 0;
      chk($sformatf("%s valid %0d", tag, k), 64'(dump_valid), 64'd1);
      chk($sformatf("%s idx %0d", tag, k), 64'(dump_idx), 64'(k));
      chk($sformatf("%s data %0d", tag, k), dump_data, m[k]);
    end
    chk({tag, " busy at end"}, 64'(dump_busy), 64'd0);
    step();
    chk({tag, " valid after"}, 64'(dump_valid), 64'd0);
  endtask
  initial begin
    tbl[0] = '{1, 4'hB, 4'hF, 4'hF, 4'hF, 0, 4'hF, 0, 4'd4, 4'd4, SPV, SPV, 1};
    tbl[1] = '{0, 4'h0, 4'hF, 4'hF, 4'hF, 0, 4'hF, 0, 4'd4, 4'd4, SPV, SPV, 0};
    tbl[2] = '{0, 4'h0, 4'hF, 4'hF, 4'd3, 64'hDEAD, 4'hF, 0, 4'd4, 4'd4, SPV, SPV, 0};
    tbl[3] = '{1, 4'h6, 4'd3, 4'd2, 4'hF, 0, 4'hF, 0, 4'd3, 4'd2, 64'hDEAD, 0, 1};
    tbl[4] = '{1, 4'h3, 4'd3, 4'd2, 4'hF, 0, 4'hF, 0, 4'hF, 4'hF, 0, 0, 1};
    tbl[5] = '{1, 4'h2, 4'd1, 4'hF, 4'd1, 64'd5, 4'd1, 64'd9, 4'd1, 4'hF, 64'd9, 0, 1};
    tbl[6] = '{1, 4'h2, 4'd1, 4'hF, 4'hF, 0, 4'hF, 0, 4'd1, 4'hF, 64'd9, 0, 1};
    tbl[7] = '{1, 4'hA, 4'd1, 4'd0, 4'hF, 0, 4'hF, 0, 4'd1, 4'd4, 64'd9, SPV, 1};
    tbl[8] = '{1, 4'h4, 4'hF, 4'hF, 4'hF, 64'h123, 4'hF, 0, 4'hF, 4'hF, 0, 0, 1};
    model_reset();
    #12;
    chk("reset srcA", 64'(srcA), 64'hF);
    chk("reset srcB", 64'(srcB), 64'hF);
    chk("reset valA", valA, 0);
    chk("reset dov", 64'(dec_out_valid), 0);
    chk("reset busy", 64'(dump_busy), 0);
    chk("reset dump_valid", 64'(dump_valid), 0);
    chk("reset dump_data", dump_data, 0);
    @(negedge clk); rst_n = 1;
    @(posedge clk); #1;
    for (int i = 0; i < 9; i++) begin
      dec_valid = tbl[i].dv; icode = tbl[i].ic; rA = tbl[i].ra; rB = tbl[i].rb;
      dstE = tbl[i].de; valE = tbl[i].ve; dstM = tbl[i].dm; valM = tbl[i].vm;
      step();
      chk($sformatf("vec%0d srcA", i), 64'(srcA), 64'(tbl[i].xa));
      chk($sformatf("vec%0d srcB", i), 64'(srcB), 64'(tbl[i].xb));
      chk($sformatf("vec%0d valA", i), valA, tbl[i].xva);
      chk($sformatf("vec%0d valB", i), valB, tbl[i].xvb);
      chk($sformatf("vec%0d dov", i), 64'(dec_out_valid), 64'(tbl[i].xdov));
    end
    dump_check("dump_prior", 0);
    idle_in();
    for (int k = 0; k < 15; k++) begin
      dstE = 4'(k); valE = 64'(k + 1);
      step();
    end
    dump_check("dump_seq", 1);
    for (int n = 0; n < 300; n++) begin
      dec_valid = 1'($urandom); icode = 4'($urandom); rA = 4'($urandom); rB = 4'($urandom);
      dstE = 4'($urandom); dstM = $urandom_range(0, 3) == 0 ? dstE : 4'($urandom);
      valE = {$urandom, $urandom}; valM = {$urandom, $urandom};
      dump_start = n == 100;
      step();
      check_dec($sformatf("rand%0d", n));
    end
    idle_in();
    repeat (20) step();
    dump_start = 1;
    begin
      int t = 0;
      while (!(dump_valid && dump_idx == 4'd5) && t < 40) begin
        step();
        dump_start = 0;
        t++;
      end
      chk("reach dump_idx 5", 64'(t < 40), 64'd1);
    end
    rst_n = 0;
    #1;
    model_reset();
    chk("midreset dump_valid", 64'(dump_valid), 0);
    chk("midreset dump_busy", 64'(dump_busy), 0);
    chk("midreset valA", valA, 0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1;
    step();
    chk("postreset dump_valid", 64'(dump_valid), 0);
    dump_check("dump_after_reset", 0);
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
endmodule

// File: doc/y86_regfile_decode.md
Name: y86_regfile_decode

Overview:
- Parametrised, clocked register file plus decode read stage for the Y86 SEQ/PIPE datapath.
- Holds the architectural registers internally instead of taking them as ports.
- Selects srcA/srcB from icode and returns valA/valB registered, with write-back bypass.
- Accepts two write-back ports (E and M) and provides a sequential debug dump engine that streams every register out, one per cycle.

Parameters:
- DATA_W, 64, register/data width in bits
- ADDR_W, 4, register index width; index 2^ADDR_W-1 is RNONE (no register)
- NREG, 15, number of implemented registers, 1 <= NREG <= 2^ADDR_W-1
- SP_IDX, 4, index of the stack pointer
- SP_INIT, 0, reset value of register SP_IDX (DATA_W bits)

Ports:
- clk  in  1  clock, all state updates on rising edge
- rst_n  in  1  asynchronous active-low reset
- dec_valid  in  1  decode request this cycle
- icode  in  4  instruction code
- rA  in  ADDR_W  instruction rA field
- rB  in  ADDR_W  instruction rB field
- dstE  in  ADDR_W  E write-back destination (RNONE = no write)
- valE  in  DATA_W  E write-back data
- dstM  in  ADDR_W  M write-back destination (RNONE = no write)
- valM  in  DATA_W  M write-back data
- dump_start  in  1  begin register dump
- srcA  out  ADDR_W  registered selected A source
- srcB  out  ADDR_W  registered selected B source
- valA  out  DATA_W  registered A operand
- valB  out  DATA_W  registered B operand
- dec_out_valid  out  1  valA/valB/srcA/srcB updated by previous-cycle request
- dump_busy  out  1  dump engine active
- dump_valid  out  1  dump_idx/dump_data valid
- dump_idx  out  ADDR_W  register index being dumped
- dump_data  out  DATA_W  register contents

Behaviour:
- Reset (rst_n low, async):
  - all registers go to 0, except register SP_IDX, which goes to SP_INIT.
  - valA, valB and dump_data go to 0; srcA and srcB go to RNONE.
  - dec_out_valid, dump_busy, dump_valid and dump_idx go to 0; FSM goes to IDLE.
  - Reset mid-dump aborts the dump with no further dump_valid.
- Source select (combinational, internal):
  - srcA = rA for icode 2,4,6,A; SP_IDX for icode 9,B; RNONE otherwise.
  - srcB = rB for icode 4,5,6; SP_IDX for icode 8,9,A,B; RNONE otherwise.
  - icode 0,1,3,7 and C-F read nothing.
- Read (latency 1):
  - On an edge with dec_valid=1, srcA/srcB/valA/valB are loaded and dec_out_valid is set to 1.
  - With dec_valid=0, dec_out_valid goes to 0 and the other read outputs hold.
- Read value per source s:
  - RNONE or s>=NREG gives 0.
  - Otherwise, if dstM==s, the value is valM.
  - Otherwise, if dstE==s, the value is valE.
  - Otherwise, the value is the stored register.
  - Bypass is from the same-cycle write-back; M has priority, matching the write rule.
- Write:
  - On each edge, dstE<NREG writes valE and dstM<NREG writes valM.
  - If dstE==dstM, valM wins.
  - Indices >=NREG (including RNONE) are ignored silently.
  - Writes and reads to the same register in one cycle are legal; the read sees the new value via bypass.
- Dump FSM:
  - IDLE to DUMP on dump_start=1; idx=0 and dump_busy=1.
  - In DUMP, each edge loads dump_idx=idx and dump_data=read(idx) (same bypass rule), sets dump_valid=1, and increments idx.
  - After loading idx=NREG-1, the FSM returns to IDLE and dump_busy=0; dump_valid is high exactly NREG consecutive cycles and 0 otherwise.
  - dump_start while in DUMP is ignored (no restart).
  - Decode reads and writes continue unaffected during a dump.
- Width:
  - All data is DATA_W bits with no arithmetic.
  - rA/rB/dst fields are compared at full ADDR_W.

Test Plan:
- Reset with SP_INIT=64'h100:
  - dec_valid, icode=B → next cycle srcA=srcB=4, valA=valB=64'h100, dec_out_valid=1.
  - Then with dec_valid=0 → dec_out_valid=0, values held.
- Write-back and read:
  - Write dstE=3/valE=64'hDEAD, then icode=6, rA=3, rB=2 → valA=64'hDEAD, valB=0.
  - icode=3 → srcA=srcB=RNONE, valA=valB=0.
- Same-cycle collision:
  - dstE=dstM=1, valE=5, valM=9, with a read of icode=2, rA=1 that cycle → valA=9; later read of reg 1 → 9.
- Out-of-range write:
  - NREG=15, dstE=15 → no register changes; a full dump matches the prior contents.
- Dump:
  - After writing reg k = k+1, pulse dump_start → dump_valid high 15 cycles, dump_idx 0..14, dump_data 1..15.
  - A second dump_start mid-dump is ignored.
- Reset mid-dump:
  - Assert rst_n=0 at dump_idx=5 → dump_valid/dump_busy go to 0 immediately, all registers reset, reg 4 = SP_INIT.
